cnn_layer_scheduler: RTL

- Central sequencer for a generated CNN top: drives the per-layer i_start / i_func_start pulses that the conv, pool and fc layers expect.
- Each layer runs a per-layer FSM: wait input ready, start the CIM phase, wait CIM busy to fall, wait a settle delay, wait the downstream layer to be free, then start the function/activation phase.
- Lets consecutive layers pipeline across frames.
- Counts completed frames.

---
 rtl/cnn_layer_scheduler_pkg.sv | 17 +
 rtl/cnn_layer_scheduler_if.sv | 30 +++
 rtl/cnn_layer_scheduler_seq.sv | 93 +++++++++
 rtl/cnn_layer_scheduler.sv | 72 +++++++
 4 files changed

// File: rtl/cnn_layer_scheduler_pkg.sv
// Shared types and helpers for the CNN layer scheduler.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MVM,
    SETTLE,
    WAIT_NEXT,
    FUNC
  } sched_state_t;

  // Width of a down-counter that must hold the value n (never narrower than 1 bit).
  function automatic int settle_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cnn_layer_scheduler_if.sv
// Handshake bundle between the scheduler and the generated layer array.
interface cnn_layer_scheduler_if #(
  parameter int num_layers      = 5,
  parameter int frame_cnt_width = 16
);

  logic                       i_enable;
  logic [num_layers-1:0]      i_ibuf_full;
  logic [num_layers-1:0]      i_layer_busy;
  logic [num_layers-1:0]      i_func_done;
  logic [num_layers-1:0]      o_start;
  logic [num_layers-1:0]      o_func_start;
  logic [num_layers-1:0]      o_next_busy;
  logic [num_layers-1:0]      o_active;
  logic                       o_frame_done;
  logic [frame_cnt_width-1:0] o_frame_cnt;

  // Scheduler side.
  modport master (
    input  i_enable, i_ibuf_full, i_layer_busy, i_func_done,
    output o_start, o_func_start, o_next_busy, o_active, o_frame_done, o_frame_cnt
  );

  // Layer-array side.
  modport slave (
    output i_enable, i_ibuf_full, i_layer_busy, i_func_done,
    input  o_start, o_func_start, o_next_busy, o_active, o_frame_done, o_frame_cnt
  );

endinterface

// File: rtl/cnn_layer_scheduler_seq.sv
// Per-layer sequencer: start the CIM phase, wait for it to finish and settle,
// wait for the downstream layer to be free, then start the function phase.
module layer_seq_fsm
  import cnn_sched_pkg::*;
#(
  parameter int settle_cycles = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_enable,
  input  logic         i_ibuf_full,
  input  logic         i_layer_busy,
  input  logic         i_func_done,
  input  logic         i_next_idle,
  input  logic         i_is_last,
  output logic         o_start,
  output logic         o_func_start,
  output sched_state_t o_state
);

  localparam int sw = settle_w(settle_cycles);

  sched_state_t  state, state_nxt;
  logic [sw-1:0] cnt, cnt_nxt;
  logic          mvm_first, mvm_first_nxt;
  logic          start_nxt, func_start_nxt;

  // State, settle counter and registered pulse outputs.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mvm_first    <= 1'b0;
      o_start      <= 1'b0;
      o_func_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mvm_first    <= mvm_first_nxt;
      o_start      <= start_nxt;
      o_func_start <= func_start_nxt;
    end
  end

  // Next-state and pulse decode.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    mvm_first_nxt  = 1'b0;
    start_nxt      = 1'b0;
    func_start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && i_ibuf_full) begin
          state_nxt     = MVM;
          mvm_first_nxt = 1'b1;
          start_nxt     = 1'b1;
        end
      end
      MVM: begin
        // The layer sees o_start during the first MVM cycle, so its busy
        // flag is only meaningful from the second cycle onward.
        if (!mvm_first && !i_layer_busy) begin
          if (settle_cycles == 0) begin
            state_nxt = WAIT_NEXT;
          end else begin
            state_nxt = SETTLE;
            cnt_nxt   = sw'(settle_cycles);
          end
        end
      end
      SETTLE: begin
        cnt_nxt = cnt - sw'(1);
        if (cnt == sw'(1)) state_nxt = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (i_is_last || i_next_idle) begin
          state_nxt      = FUNC;
          func_start_nxt = 1'b1;
        end
      end
      FUNC: begin
        if (i_func_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_state = state;

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Central sequencer for the generated CNN: one layer_seq_fsm per layer,
// downstream-busy chaining between neighbours, and the completed-frame counter.
module cnn_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int num_layers      = 5,
  parameter int settle_cycles   = 4,
  parameter int frame_cnt_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cnn_layer_scheduler_if.master bus
);

  sched_state_t               layer_state [num_layers];
  logic [num_layers-1:0]      active;
  logic [num_layers-1:0]      next_idle;
  logic [num_layers-1:0]      start_vec;
  logic [num_layers-1:0]      func_start_vec;
  logic                       last_done;
  logic                       frame_done_q;
  logic [frame_cnt_width-1:0] frame_cnt_q;

  // Decode which layers are out of IDLE; all derived from state registers.
  always_comb begin
    active = '0;
    for (int k = 0; k < num_layers; k++) active[k] = (layer_state[k] != IDLE);
  end

  // Bit k looks at layer k+1; the top bit shifts in 0 (nothing downstream).
  assign next_idle = ~(active >> 1);

  for (genvar k = 0; k < num_layers; k++) begin : g_layer
    layer_seq_fsm #(
      .settle_cycles (settle_cycles)
    ) u_seq (
      .clk          (clk),
      .rst          (rst),
      .i_enable     (bus.i_enable),
      .i_ibuf_full  (bus.i_ibuf_full[k]),
      .i_layer_busy (bus.i_layer_busy[k]),
      .i_func_done  (bus.i_func_done[k]),
      .i_next_idle  (next_idle[k]),
      .i_is_last    (k == num_layers - 1),
      .o_start      (start_vec[k]),
      .o_func_start (func_start_vec[k]),
      .o_state      (layer_state[k])
    );
  end

  // The last layer leaving FUNC is the same edge that completes a frame.
  assign last_done = (layer_state[num_layers-1] == FUNC) && bus.i_func_done[num_layers-1];

  // Frame-done pulse and wrapping completed-frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= last_done;
      if (last_done) frame_cnt_q <= frame_cnt_q + frame_cnt_width'(1);
    end
  end

  assign bus.o_start      = start_vec;
  assign bus.o_func_start = func_start_vec;
  assign bus.o_active     = active;
  assign bus.o_next_busy  = active >> 1;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_frame_cnt  = frame_cnt_q;

endmodule
